// File: rtl/stopwatch_accum_ctrl.sv
// Stopwatch sequencing controller: owns elapsed count and last-lap registers and
// time-shares one external 16-bit adder between tick increments and lap splits.
module stopwatch_accum_ctrl #(
  parameter int unsigned MAX_COUNT = 59999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_s,
  input  logic        add_cout,
  output logic [15:0] count,
  output logic [15:0] split,
  output logic        split_valid,
  output logic        running,
  output logic        busy,
  output logic        overflow,
  output logic        overrun
);

  localparam logic [15:0] MAX_C = 16'(MAX_COUNT);
  localparam logic [15:0] MOD_C = 16'(MAX_COUNT + 1);

  typedef enum logic {
    STOPPED,
    RUNNING
  } run_state_e;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_INC,
    OP_SUB
  } op_e;

  run_state_e  run_q, run_d;
  op_e         op_q, op_d;
  logic [15:0] count_q, count_d;
  logic [15:0] last_lap_q, last_lap_d;
  logic [15:0] split_q, split_d;
  logic        split_valid_q, split_valid_d;
  logic        overflow_q, overflow_d;
  logic        overrun_q, overrun_d;
  logic        tick_pend_q, tick_pend_d;
  logic        lap_pend_q, lap_pend_d;
  logic        tick_req;
  logic        lap_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q         <= STOPPED;
      op_q          <= OP_NONE;
      count_q       <= '0;
      last_lap_q    <= '0;
      split_q       <= '0;
      split_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      overrun_q     <= 1'b0;
      tick_pend_q   <= 1'b0;
      lap_pend_q    <= 1'b0;
    end else begin
      run_q         <= run_d;
      op_q          <= op_d;
      count_q       <= count_d;
      last_lap_q    <= last_lap_d;
      split_q       <= split_d;
      split_valid_q <= split_valid_d;
      overflow_q    <= overflow_d;
      overrun_q     <= overrun_d;
      tick_pend_q   <= tick_pend_d;
      lap_pend_q    <= lap_pend_d;
    end
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (op_q)
      OP_INC: begin
        add_a   = count_q;
        add_cin = 1'b1;
      end
      OP_SUB: begin
        add_a   = count_q;
        add_b   = ~last_lap_q;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    run_d         = run_q;
    op_d          = OP_NONE;
    count_d       = count_q;
    last_lap_d    = last_lap_q;
    split_d       = split_q;
    split_valid_d = 1'b0;
    overflow_d    = overflow_q;
    overrun_d     = overrun_q;
    tick_pend_d   = tick_pend_q;
    lap_pend_d    = lap_pend_q;
    tick_req      = tick | tick_pend_q;
    lap_req       = lap | lap_pend_q;

    if (start_stop) begin
      run_d = (run_q == RUNNING) ? STOPPED : RUNNING;
    end

    case (op_q)
      OP_INC: begin
        if (count_q == MAX_C) begin
          count_d    = '0;
          overflow_d = 1'b1;
        end else begin
          count_d = add_s;
        end
      end
      OP_SUB: begin
        // A borrow means the count wrapped since the last lap; add one period back.
        split_d       = add_cout ? add_s : add_s + MOD_C;
        last_lap_d    = count_q;
        split_valid_d = 1'b1;
      end
      default: ;
    endcase

    if (run_q == RUNNING) begin
      if (start_stop) begin
        tick_pend_d = 1'b0;
        lap_pend_d  = 1'b0;
      end else begin
        if (tick && tick_pend_q) overrun_d = 1'b1;
        if (lap && lap_pend_q) overrun_d = 1'b1;
        if (tick_req) begin
          op_d        = OP_INC;
          tick_pend_d = 1'b0;
          lap_pend_d  = lap_req;
        end else if (lap_req) begin
          op_d       = OP_SUB;
          lap_pend_d = 1'b0;
        end
      end
    end else if (clear) begin
      // Clear overrides the result capture of any op still in flight.
      count_d       = '0;
      last_lap_d    = '0;
      split_d       = '0;
      split_valid_d = 1'b0;
      overflow_d    = 1'b0;
      overrun_d     = 1'b0;
      tick_pend_d   = 1'b0;
      lap_pend_d    = 1'b0;
    end
  end

  assign count       = count_q;
  assign split       = split_q;
  assign split_valid = split_valid_q;
  assign running     = (run_q == RUNNING);
  assign busy        = (op_q != OP_NONE);
  assign overflow    = overflow_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_stopwatch_accum_ctrl.sv
// Directed bench for stopwatch_accum_ctrl: one instance at MAX_COUNT=59999, one at 9,
// each with a behavioural ripple adder; lap splits are checked through a scoreboard queue.
module tb_stopwatch_accum_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic        a_tick, a_ss, a_clear, a_lap;
  logic [15:0] a_add_a, a_add_b, a_add_s, a_count, a_split;
  logic        a_add_cin, a_add_cout, a_sv, a_running, a_busy, a_ovf, a_ovr;

  logic        b_tick, b_ss, b_clear, b_lap;
  logic [15:0] b_add_a, b_add_b, b_add_s, b_count, b_split;
  logic        b_add_cin, b_add_cout, b_sv, b_running, b_busy, b_ovf, b_ovr;

  int checks_total  = 0;
  int checks_passed = 0;
  logic [15:0] sb_a[$];
  logic [15:0] sb_b[$];

  always #5 clk = ~clk;

  assign {a_add_cout, a_add_s} = {1'b0, a_add_a} + {1'b0, a_add_b} + {16'd0, a_add_cin};
  assign {b_add_cout, b_add_s} = {1'b0, b_add_a} + {1'b0, b_add_b} + {16'd0, b_add_cin};

  stopwatch_accum_ctrl dut_a (
    .clk(clk), .rst(rst), .tick(a_tick), .start_stop(a_ss), .clear(a_clear), .lap(a_lap),
    .add_a(a_add_a), .add_b(a_add_b), .add_cin(a_add_cin), .add_s(a_add_s),
    .add_cout(a_add_cout), .count(a_count), .split(a_split), .split_valid(a_sv),
    .running(a_running), .busy(a_busy), .overflow(a_ovf), .overrun(a_ovr)
  );

  stopwatch_accum_ctrl #(.MAX_COUNT(9)) dut_b (
    .clk(clk), .rst(rst), .tick(b_tick), .start_stop(b_ss), .clear(b_clear), .lap(b_lap),
    .add_a(b_add_a), .add_b(b_add_b), .add_cin(b_add_cin), .add_s(b_add_s),
    .add_cout(b_add_cout), .count(b_count), .split(b_split), .split_valid(b_sv),
    .running(b_running), .busy(b_busy), .overflow(b_ovf), .overrun(b_ovr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (bounded) for the next split_valid pulse of one instance and pops its expectation.
  task automatic wait_split(input bit sel, input string tag);
    logic        found;
    logic [15:0] exp;
    found = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if ((sel ? b_sv : a_sv) === 1'b1) begin
        found = 1'b1;
        break;
      end
      cyc(1);
    end
    chk({tag, "_seen"}, {31'd0, found}, 32'd1);
    if (found) begin
      chk({tag, "_sb_nonempty"}, {31'd0, ((sel ? sb_b.size() : sb_a.size()) != 0)}, 32'd1);
      if ((sel ? sb_b.size() : sb_a.size()) != 0) begin
        exp = sel ? sb_b.pop_front() : sb_a.pop_front();
        chk(tag, {16'd0, (sel ? b_split : a_split)}, {16'd0, exp});
      end
      cyc(1);
      chk({tag, "_pulse_width"}, {31'd0, (sel ? b_sv : a_sv)}, 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_seen;
    rst = 1'b1;
    a_tick = 0; a_ss = 0; a_clear = 0; a_lap = 0;
    b_tick = 0; b_ss = 0; b_clear = 0; b_lap = 0;
    cyc(2);
    chk("rst_a_count", {16'd0, a_count}, 32'd0);
    chk("rst_a_split", {16'd0, a_split}, 32'd0);
    chk("rst_a_sv", {31'd0, a_sv}, 32'd0);
    chk("rst_a_running", {31'd0, a_running}, 32'd0);
    chk("rst_a_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_a_flags", {30'd0, a_ovf, a_ovr}, 32'd0);
    chk("rst_a_adder", {a_add_a, a_add_b} | {31'd0, a_add_cin}, 32'd0);
    chk("rst_b_count", {16'd0, b_count}, 32'd0);
    rst = 1'b0;
    cyc(1);

    // Asynchronous reset with count=37 and an INC in flight.
    a_ss = 1; cyc(1); a_ss = 0;
    chk("a_running", {31'd0, a_running}, 32'd1);
    a_tick = 1; cyc(38); a_tick = 0;
    chk("a_pre_rst_count", {16'd0, a_count}, 32'd37);
    chk("a_pre_rst_busy", {31'd0, a_busy}, 32'd1);
    chk("a_pre_rst_add_a", {16'd0, a_add_a}, 32'd37);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", {16'd0, a_count}, 32'd0);
    chk("async_rst_running", {31'd0, a_running}, 32'd0);
    chk("async_rst_busy", {31'd0, a_busy}, 32'd0);
    chk("async_rst_adder", {a_add_a, 15'd0, a_add_cin}, 32'd0);
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // Five spaced ticks, then ticks while stopped.
    a_ss = 1; cyc(1); a_ss = 0;
    busy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      a_tick = 1; cyc(1); a_tick = 0;
      busy_seen += int'(a_busy);
      cyc(1); busy_seen += int'(a_busy);
      cyc(1); busy_seen += int'(a_busy);
      chk("a_tick_count", {16'd0, a_count}, 32'(i + 1));
    end
    chk("a_busy_cycles", 32'(busy_seen), 32'd5);
    chk("a_no_overflow", {31'd0, a_ovf}, 32'd0);
    a_ss = 1; cyc(1); a_ss = 0;
    chk("a_stopped", {31'd0, a_running}, 32'd0);
    a_tick = 1; cyc(1); a_tick = 0;
    chk("a_stopped_busy", {31'd0, a_busy}, 32'd0);
    cyc(1);
    chk("a_stopped_count", {16'd0, a_count}, 32'd5);
    a_clear = 1; cyc(1); a_clear = 0;
    chk("a_clear_count", {16'd0, a_count}, 32'd0);

    // Lap splits at 120 and 200.
    a_ss = 1; cyc(1); a_ss = 0;
    a_tick = 1; cyc(120); a_tick = 0; cyc(1);
    chk("a_count_120", {16'd0, a_count}, 32'd120);
    sb_a.push_back(16'd120);
    a_lap = 1; cyc(1); a_lap = 0;
    chk("a_sub1_cout", {31'd0, a_add_cout}, 32'd1);
    wait_split(1'b0, "a_split_120");
    a_tick = 1; cyc(80); a_tick = 0; cyc(1);
    chk("a_count_200", {16'd0, a_count}, 32'd200);
    sb_a.push_back(16'd80);
    a_lap = 1; cyc(1); a_lap = 0;
    wait_split(1'b0, "a_split_80");

    // Tick and lap on the same edge: INC then SUB.
    sb_a.push_back(16'd1);
    a_tick = 1; a_lap = 1; cyc(1); a_tick = 0; a_lap = 0;
    chk("a_same_inc_b", {16'd0, a_add_b}, 32'd0);
    chk("a_same_inc_a", {16'd0, a_add_a}, 32'd200);
    cyc(1);
    chk("a_same_sub_a", {16'd0, a_add_a}, 32'd201);
    chk("a_same_sub_b", {16'd0, a_add_b}, 32'd65335);
    wait_split(1'b0, "a_split_same_edge");
    chk("a_count_201", {16'd0, a_count}, 32'd201);

    // Ticks while lap pending, then a second lap before service.
    sb_a.push_back(16'd5);
    a_tick = 1; a_lap = 1; cyc(1); a_lap = 0;
    cyc(3);
    chk("a_overrun_hold", {31'd0, a_ovr}, 32'd0);
    a_lap = 1; cyc(1); a_lap = 0; a_tick = 0;
    chk("a_overrun_set", {31'd0, a_ovr}, 32'd1);
    wait_split(1'b0, "a_split_pending");
    chk("a_count_206", {16'd0, a_count}, 32'd206);

    // MAX_COUNT=9 wrap, clear rules.
    b_ss = 1; cyc(1); b_ss = 0;
    for (int i = 1; i <= 10; i++) begin
      b_tick = 1; cyc(1); b_tick = 0; cyc(1);
      chk("b_wrap_count", {16'd0, b_count}, 32'(i % 10));
      if (i == 9) chk("b_ovf_before_wrap", {31'd0, b_ovf}, 32'd0);
    end
    chk("b_ovf_after_wrap", {31'd0, b_ovf}, 32'd1);
    b_tick = 1; cyc(1); b_tick = 0; cyc(1);
    b_clear = 1; cyc(1); b_clear = 0; cyc(1);
    chk("b_clear_running_count", {16'd0, b_count}, 32'd1);
    chk("b_clear_running_ovf", {31'd0, b_ovf}, 32'd1);
    b_ss = 1; cyc(1); b_ss = 0;
    b_clear = 1; cyc(1); b_clear = 0;
    chk("b_clear_count", {16'd0, b_count}, 32'd0);
    chk("b_clear_ovf", {31'd0, b_ovf}, 32'd0);
    chk("b_clear_running", {31'd0, b_running}, 32'd0);

    // Lap across a wrap: borrow correction.
    b_ss = 1; cyc(1); b_ss = 0;
    b_tick = 1; cyc(7); b_tick = 0; cyc(1);
    chk("b_count_7", {16'd0, b_count}, 32'd7);
    sb_b.push_back(16'd7);
    b_lap = 1; cyc(1); b_lap = 0;
    wait_split(1'b1, "b_split_7");
    b_tick = 1; cyc(6); b_tick = 0; cyc(1);
    chk("b_count_3", {16'd0, b_count}, 32'd3);
    sb_b.push_back(16'd6);
    b_lap = 1; cyc(1); b_lap = 0;
    chk("b_borrow_cout", {31'd0, b_add_cout}, 32'd0);
    chk("b_borrow_a", {16'd0, b_add_a}, 32'd3);
    wait_split(1'b1, "b_split_wrap");

    cyc(3);
    chk("sb_a_drained", 32'(sb_a.size()), 32'd0);
    chk("sb_b_drained", 32'(sb_b.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
